seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Purpose: time-multiplexed 8-digit scan controller; drives the hex-to-7-segment decoder stage with one nibble plus an active-low anode vector per digit slot.

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter LZB, default 0, leading-zero blanking enable (1 = on).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 init  input  1  scan enable; 0 = display dark and scan halted.
REQ-006 load  input  1  single-cycle strobe: capture value.
REQ-007 value  input  32  eight hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
REQ-008 digit_en  input  8  per-digit enable mask, sampled live; bit k=0 blanks digit k.
REQ-009 n  output  4  registered nibble for the active slot, to decoder.
REQ-010 anode  output  8  registered, active-low, at most one bit low.
REQ-011 frame  output  1  registered one-cycle pulse at each frame boundary.

Function
REQ-012 States: IDLE (init=0) and SCAN (init=1); transition evaluated every cycle.
REQ-013 IDLE: div counter held 0, slot index held 0, anode=8'hFF, n=0, frame=0.
REQ-014 SCAN: div counter counts 0..CLK_DIV-1 and wraps; tick = counter at CLK_DIV-1.
REQ-015 On tick, slot index advances k -> (k+1) mod 8; 7 -> 0 is a frame boundary.
REQ-016 IDLE->SCAN: first cycle in SCAN drives slot 0; no tick is required to light slot 0.
REQ-017 anode and n update on the same edge as the slot index; anode bit k low, all others high, n = display digit k.
REQ-018 Blanked slot (digit_en[k]=0, or LZB-blanked): anode=8'hFF for the whole slot; index still advances; slot duration unchanged.
REQ-019 LZB=1: digit k (k>=1) blanked when display digits k..7 are all zero; digit 0 never LZB-blanked.
REQ-020 Double buffer: load writes pending register and sets pend flag; display register unaffected.
REQ-021 Commit: at a frame boundary with pend=1, pending -> display and pend cleared on that edge; the new slot 0 shows the committed value.
REQ-022 load while pend=1 overwrites pending (last write wins); load coincident with a frame boundary is committed at the next boundary, not the current one.
REQ-023 load accepted in IDLE; IDLE->SCAN with pend=1 commits on the entry edge, before slot 0 is driven.
REQ-024 frame asserted for exactly the cycle following each 7->0 transition; never in IDLE.
REQ-025 init falling mid-slot: next edge enters IDLE per REQ-013; pending/display retained.

Reset
REQ-026 rst overrides all inputs: counter=0, index=0, display=0, pending=0, pend=0, anode=8'hFF, n=0, frame=0, state IDLE.
REQ-027 rst asserted mid-scan takes effect at the next edge; operation resumes per REQ-016 on the first edge with rst=0 and init=1.

Verification (CLK_DIV=4 unless noted)
REQ-028 rst, load value=32'h12345678, init=1 -> anode FE/n=8 for 4 cycles, then FD/7, FB/6, ... 7F/1; frame pulses after 7F->FE.
REQ-029 Mid-frame load 32'hDEADBEEF -> remaining slots of the current frame show old digits; next frame slot 0 shows n=F.
REQ-030 Two loads (32'h1, then 32'h2) in one frame -> only 32'h2 is displayed; 32'h1 never appears.
REQ-031 digit_en=8'h0F -> slots 4..7 give anode=FF for 4 cycles each; frame period remains 32 cycles.
REQ-032 LZB=1, value=32'h00000A05 -> digits 0..2 lit (n=5,0,A), slots 3..7 anode=FF.
REQ-033 init dropped at slot 3 then rst pulsed -> anode=FF, n=0, frame=0; init=1 restarts at slot 0 with display 0.

Source files
------------

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Brief    : 8-digit time-multiplexed scan controller with double-buffered
//            value, per-digit enable and optional leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter bit LZB     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  output logic [3:0]  n,
  output logic [7:0]  anode,
  output logic        frame
);

  localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_TICK  = c_CNT_W'(CLK_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [31:0]          r_display;
  logic [31:0]          r_pending;
  logic [31:0]          w_disp_nxt;
  logic                 r_pend;
  logic                 w_commit;
  logic                 w_frame_nxt;
  logic                 w_active;
  logic                 w_tick;
  logic [7:0]           r_anode;
  logic [7:0]           w_anode_nxt;
  logic [3:0]           r_n;
  logic [3:0]           w_n_nxt;
  logic                 r_frame;
  logic [7:0]           w_zero_from;
  logic                 w_blank;

  assign w_tick = (r_cnt == c_TICK);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_commit    = 1'b0;
    w_frame_nxt = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = 3'd0;
        if (init) begin
          // Entry edge commits a pending value so slot 0 already shows it.
          w_state_nxt = S_SCAN;
          w_commit    = r_pend;
          w_active    = 1'b1;
        end
      end
      S_SCAN: begin
        if (!init) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
        end else begin
          w_active = 1'b1;
          if (w_tick) begin
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              w_commit    = r_pend;
              w_frame_nxt = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are derived from the post-edge slot and display contents.
  assign w_disp_nxt = w_commit ? r_pending : r_display;

  for (genvar k = 0; k < 8; k++) begin : g_lzb
    assign w_zero_from[k] = ~|w_disp_nxt[31:4*k];
  end

  assign w_blank = ~digit_en[w_idx_nxt]
                 | (LZB && (w_idx_nxt != 3'd0) && w_zero_from[w_idx_nxt]);

  always_comb begin
    w_anode_nxt = 8'hFF;
    w_n_nxt     = 4'h0;
    if (w_active) begin
      w_n_nxt = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
      if (!w_blank) begin
        w_anode_nxt = ~(8'd1 << w_idx_nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_display <= 32'h0;
      r_pending <= 32'h0;
      r_pend    <= 1'b0;
      r_anode   <= 8'hFF;
      r_n       <= 4'h0;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_display <= w_disp_nxt;
      if (load) begin
        r_pending <= value;
      end
      // A load on the commit edge stays pending for the following boundary.
      r_pend    <= load | (r_pend & ~w_commit);
      r_anode   <= w_anode_nxt;
      r_n       <= w_n_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign n     = r_n;
  assign anode = r_anode;
  assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan
// Brief    : Directed bench for seg_scan with CLK_DIV=4, LZB off and on.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        load;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [3:0]  n1;
  logic [7:0]  anode1;
  logic        frame1;
  logic [3:0]  n2;
  logic [7:0]  anode2;
  logic        frame2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan #(.CLK_DIV(4), .LZB(1'b0)) u_dut (
    .clk(clk), .rst(rst), .init(init), .load(load), .value(value),
    .digit_en(digit_en), .n(n1), .anode(anode1), .frame(frame1)
  );

  seg_scan #(.CLK_DIV(4), .LZB(1'b1)) u_dut_lzb (
    .clk(clk), .rst(rst), .init(init), .load(load), .value(value),
    .digit_en(digit_en), .n(n2), .anode(anode2), .frame(frame2)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Walks one 32-cycle frame from slot 0 cycle 0, optionally pulsing load at
  // frame positions la/lb (position = slot*4 + cycle).
  task automatic run_frame(input logic [31:0] v, input logic [7:0] en, input bit first,
                           input bit chk2, input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        int         pos;
        logic [7:0] ea;
        logic [3:0] ed;
        logic       lit2;
        pos  = s * 4 + c;
        ea   = ~(8'd1 << s);
        ed   = v[4*s +: 4];
        lit2 = en[s] && ((s == 0) || ((v >> (4 * s)) != 32'h0));
        chk($sformatf("anode s%0d c%0d", s, c), {24'h0, anode1}, en[s] ? {24'h0, ea} : 32'hFF);
        if (en[s]) chk($sformatf("n s%0d c%0d", s, c), {28'h0, n1}, {28'h0, ed});
        chk($sformatf("frame s%0d c%0d", s, c), {31'h0, frame1}, {31'h0, (pos == 0) && !first});
        if (chk2) begin
          chk($sformatf("lzb anode s%0d", s), {24'h0, anode2}, lit2 ? {24'h0, ea} : 32'hFF);
          if (lit2) chk($sformatf("lzb n s%0d", s), {28'h0, n2}, {28'h0, ed});
          chk($sformatf("lzb frame s%0d c%0d", s, c), {31'h0, frame2}, {31'h0, (pos == 0) && !first});
        end
        if (pos == la) begin
          load = 1'b1; value = va;
        end else if (pos == lb) begin
          load = 1'b1; value = vb;
        end
        step();
        load = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; load = 1'b0; value = 32'h0; digit_en = 8'hFF;
    step();
    step();
    chk("reset anode", {24'h0, anode1}, 32'hFF);
    chk("reset n", {28'h0, n1}, 32'h0);
    chk("reset frame", {31'h0, frame1}, 32'h0);
    chk("reset lzb anode", {24'h0, anode2}, 32'hFF);

    // Load while idle; entry edge commits it before slot 0 lights.
    rst = 1'b0; load = 1'b1; value = 32'h12345678;
    step();
    load = 1'b0;
    chk("idle after load anode", {24'h0, anode1}, 32'hFF);
    chk("idle after load n", {28'h0, n1}, 32'h0);
    init = 1'b1;
    step();
    run_frame(32'h12345678, 8'hFF, 1'b1, 1'b0, -1, 32'h0, -1, 32'h0);

    // Mid-frame load shows only at the next frame.
    run_frame(32'h12345678, 8'hFF, 1'b0, 1'b0, 17, 32'hDEADBEEF, -1, 32'h0);
    run_frame(32'hDEADBEEF, 8'hFF, 1'b0, 1'b0, 5, 32'h1, 20, 32'h2);
    run_frame(32'h00000002, 8'hFF, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0);

    // Enable mask plus a load on the frame-boundary edge.
    digit_en = 8'h0F;
    run_frame(32'h00000002, 8'h0F, 1'b0, 1'b0, 31, 32'h00000A05, -1, 32'h0);
    digit_en = 8'hFF;
    run_frame(32'h00000002, 8'hFF, 1'b0, 1'b0, -1, 32'h0, -1, 32'h0);
    run_frame(32'h00000A05, 8'hFF, 1'b0, 1'b1, -1, 32'h0, -1, 32'h0);

    // Drop init in slot 3, then reset; restart from slot 0 with display 0.
    for (int i = 0; i < 13; i++) step();
    init = 1'b0;
    step();
    chk("init drop anode", {24'h0, anode1}, 32'hFF);
    chk("init drop n", {28'h0, n1}, 32'h0);
    chk("init drop frame", {31'h0, frame1}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post rst anode", {24'h0, anode1}, 32'hFF);
    chk("post rst n", {28'h0, n1}, 32'h0);
    chk("post rst frame", {31'h0, frame1}, 32'h0);
    init = 1'b1;
    step();
    run_frame(32'h0, 8'hFF, 1'b1, 1'b1, -1, 32'h0, -1, 32'h0);
    chk("restart frame pulse", {31'h0, frame1}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
